// File: rtl/floppy_bufarb.sv
// Arbitrates one single-port sector-buffer RAM between the WD1793, the SPI DMA and the 6502.
// Latency: grant and RAM drive one ce edge after request; read data valid on the following ce cycle.
// Backpressure: losers keep requesting (cpu_stall shows the CPU wait); a starving CPU is forced through.
module floppy_bufarb #(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          wd_req,
    input  logic          wd_we,
    input  logic [AW-1:0] wd_addr,
    input  logic [7:0]    wd_wdata,
    output logic          wd_gnt,
    output logic          wd_rvalid,
    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    rdata,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_WD   = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_t;

    owner_t          owner_q;
    owner_t          owner_d;
    logic [CW-1:0]   cpu_wait;
    logic [CW-1:0]   cpu_wait_d;
    logic [AW-1:0]   nxt_addr;
    logic            nxt_we;
    logic [7:0]      nxt_wdata;
    logic            wd_elig;
    logic            dma_elig;
    logic            cpu_elig;
    logic            cpu_starved;
    logic            dma_hold;

    // A grant lasts exactly as long as the registered owner says so.
    assign wd_gnt    = (owner_q == OWN_WD);
    assign dma_gnt   = (owner_q == OWN_DMA);
    assign cpu_gnt   = (owner_q == OWN_CPU);
    assign owner     = owner_q;
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign rdata     = mem_rdata;

    // A requester currently holding the bus is masked so it cannot be served twice in a row.
    assign wd_elig     = wd_req & ~wd_gnt;
    assign dma_elig    = dma_req & ~dma_gnt;
    assign cpu_elig    = cpu_req & ~cpu_gnt;
    assign cpu_starved = (cpu_wait == CW'(STARVE_MAX));
    // A locked burst reserves the buffer for DMA, even on its own masked cycles.
    assign dma_hold    = dma_lock & dma_req;

    // Pick the winner for the next access and update the CPU starvation counter.
    always_comb begin
        owner_d    = OWN_IDLE;
        nxt_addr   = mem_addr;
        nxt_we     = 1'b0;
        nxt_wdata  = mem_wdata;
        cpu_wait_d = cpu_wait;
        if (cpu_elig && cpu_starved) begin
            owner_d = OWN_CPU;
        end else if (wd_elig) begin
            owner_d = OWN_WD;
        end else if (dma_elig) begin
            owner_d = OWN_DMA;
        end else if (cpu_elig && !dma_hold) begin
            owner_d = OWN_CPU;
        end
        case (owner_d)
            OWN_WD: begin
                nxt_addr  = wd_addr;
                nxt_we    = wd_we;
                nxt_wdata = wd_wdata;
            end
            OWN_DMA: begin
                nxt_addr  = dma_addr;
                nxt_we    = dma_we;
                nxt_wdata = dma_wdata;
            end
            OWN_CPU: begin
                nxt_addr  = cpu_addr;
                nxt_we    = cpu_we;
                nxt_wdata = cpu_wdata;
            end
            default: ;
        endcase
        if (!cpu_req || owner_d == OWN_CPU) begin
            cpu_wait_d = '0;
        end else if (cpu_elig && !cpu_starved) begin
            cpu_wait_d = cpu_wait + CW'(1);
        end
    end

    // Register the winning access and the read-valid that follows a read grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= OWN_IDLE;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            cpu_wait   <= '0;
            wd_rvalid  <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else if (ce) begin
            owner_q    <= owner_d;
            mem_addr   <= nxt_addr;
            mem_we     <= nxt_we;
            mem_wdata  <= nxt_wdata;
            cpu_wait   <= cpu_wait_d;
            wd_rvalid  <= wd_gnt  & ~mem_we;
            dma_rvalid <= dma_gnt & ~mem_we;
            cpu_rvalid <= cpu_gnt & ~mem_we;
        end
    end

endmodule

// File: tb/tb_floppy_bufarb.sv
// Directed bench for floppy_bufarb with a behavioural buffer RAM behind the mem_* port.
// Latency: inputs change and outputs are checked on the falling edge, between active edges.
// Backpressure: requesters drop their request once they see their grant.
module tb_floppy_bufarb;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ce;
    logic          wd_req, wd_we;
    logic [AW-1:0] wd_addr;
    logic [7:0]    wd_wdata;
    logic          wd_gnt, wd_rvalid;
    logic          dma_req, dma_lock, dma_we;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wdata;
    logic          dma_gnt, dma_rvalid;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_gnt, cpu_rvalid, cpu_stall;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [7:0]    rdata;
    logic [1:0]    owner;

    logic [7:0]    ram [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    floppy_bufarb #(.AW(AW), .STARVE_MAX(8)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .wd_req(wd_req), .wd_we(wd_we), .wd_addr(wd_addr), .wd_wdata(wd_wdata),
        .wd_gnt(wd_gnt), .wd_rvalid(wd_rvalid),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    // Behavioural single-port buffer RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int rv_count;

    initial begin
        reset_n  = 1'b0;
        ce       = 1'b1;
        wd_req   = 0; wd_we  = 0; wd_addr  = '0; wd_wdata  = '0;
        dma_req  = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        cpu_req  = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        step(); step();
        chk("rst_owner", 32'(owner), 0);
        chk("rst_gnts", {wd_gnt, dma_gnt, cpu_gnt}, 0);
        chk("rst_rvalid", {wd_rvalid, dma_rvalid, cpu_rvalid}, 0);
        chk("rst_mem", {mem_we, 10'(mem_addr), mem_wdata}, 0);
        reset_n = 1'b1;
        step();
        chk("idle_owner", 32'(owner), 0);

        // Three simultaneous requesters served in priority order.
        wd_req  = 1; wd_we  = 0; wd_addr  = 10'h005;
        dma_req = 1; dma_we = 1; dma_addr = 10'h100; dma_wdata = 8'hA5;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        step();
        chk("p1_owner", 32'(owner), 1);
        chk("p1_gnts", {wd_gnt, dma_gnt, cpu_gnt}, 3'b100);
        chk("p1_addr", 32'(mem_addr), 32'h005);
        chk("p1_we", 32'(mem_we), 0);
        chk("p1_stall", 32'(cpu_stall), 1);
        wd_req = 0;
        step();
        chk("p2_owner", 32'(owner), 2);
        chk("p2_wd_rvalid", 32'(wd_rvalid), 1);
        chk("p2_we", 32'(mem_we), 1);
        chk("p2_wdata", 32'(mem_wdata), 32'hA5);
        chk("p2_addr", 32'(mem_addr), 32'h100);
        dma_req = 0;
        step();
        chk("p3_owner", 32'(owner), 3);
        chk("p3_rvalids", {wd_rvalid, dma_rvalid, cpu_rvalid}, 0);
        chk("p3_we", 32'(mem_we), 0);
        chk("p3_stall", 32'(cpu_stall), 0);
        chk("p3_ram", 32'(ram[10'h100]), 32'hA5);
        cpu_req = 0;
        step();
        chk("p4_owner", 32'(owner), 0);
        chk("p4_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("p4_addr_hold", 32'(mem_addr), 32'h010);
        chk("p4_we", 32'(mem_we), 0);
        step();
        chk("p5_cpu_rvalid", 32'(cpu_rvalid), 0);

        // Lone CPU requester alternates with its own mask.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h020;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("alt_gnt%0d", i), 32'(cpu_gnt), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("alt_owner%0d", i), 32'(owner), (i % 2 == 0) ? 3 : 0);
        end
        cpu_req = 0;
        step(); step();

        // Locked DMA burst starves the CPU until eight losses accumulate.
        dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 10'h200;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h030;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("starve_owner%0d", i), 32'(owner), (i % 2 == 0) ? 2 : 0);
            chk($sformatf("starve_stall%0d", i), 32'(cpu_stall), 1);
            if (dma_gnt) dma_addr = dma_addr + 10'd1;
        end
        step();
        chk("starve_win_owner", 32'(owner), 3);
        chk("starve_win_gnt", 32'(cpu_gnt), 1);
        chk("starve_win_stall", 32'(cpu_stall), 0);
        chk("starve_win_addr", 32'(mem_addr), 32'h030);
        cpu_req = 0;
        step();
        chk("starve_after_owner", 32'(owner), 2);
        dma_req = 0; dma_lock = 0;
        step(); step();

        // Clock enable gaps stretch a WD read without duplicating rvalid.
        wd_req = 1; wd_we = 0; wd_addr = 10'h040;
        rv_count = 0;
        step();
        chk("ce_gnt_a", 32'(wd_gnt), 1);
        wd_req = 0; ce = 0;
        step();
        chk("ce_gnt_b", {wd_gnt, wd_rvalid}, 2'b10);
        step();
        chk("ce_gnt_c", {wd_gnt, wd_rvalid}, 2'b10);
        ce = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (wd_rvalid) rv_count++;
            if (i == 0) chk("ce_rvalid_d", {wd_gnt, wd_rvalid}, 2'b01);
        end
        chk("ce_rvalid_count", 32'(rv_count), 1);

        // Reset during a CPU read grant discards the access.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h050;
        step();
        chk("rst2_gnt", 32'(cpu_gnt), 1);
        cpu_req = 0;
        #2 reset_n = 0;
        #1;
        chk("rst2_async", {cpu_gnt, 2'(owner), 10'(mem_addr)}, 0);
        step();
        reset_n = 1;
        rv_count = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpu_rvalid) rv_count++;
        end
        chk("rst2_no_rvalid", 32'(rv_count), 0);

        // Top-of-buffer write by WD then read back by the CPU.
        wd_req = 1; wd_we = 1; wd_addr = 10'h3FF; wd_wdata = 8'h3C;
        step();
        chk("top_wd_gnt", {wd_gnt, mem_we}, 2'b11);
        chk("top_wd_addr", 32'(mem_addr), 32'h3FF);
        wd_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
        step();
        chk("top_cpu_owner", 32'(owner), 3);
        chk("top_wd_rvalid", 32'(wd_rvalid), 0);
        cpu_req = 0;
        step();
        chk("top_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("top_rdata", 32'(rdata), 32'h3C);
        chk("top_addr", 32'(mem_addr), 32'h3FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/floppy_bufarb.md
FLOPPY_BUFARB -- requirements
Module: floppy_bufarb

Interface
REQ-001 SHALL have parameter AW, default 10: sector-buffer address width.
REQ-002 SHALL have parameter STARVE_MAX, default 8: CPU-loss count that forces a CPU grant.
REQ-003 SHALL have port clk  in  1: sole clock; all state changes on posedge clk.
REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port ce  in  1: clock enable; state advances only on edges with ce=1.
REQ-006 SHALL have ports wd_req, wd_we  in  1 each: WD1793 buffer access request and write flag.
REQ-007 SHALL have ports wd_addr  in  AW and wd_wdata  in  8: WD1793 address and write data.
REQ-008 SHALL have ports wd_gnt, wd_rvalid  out  1 each: WD1793 grant and read-data-valid.
REQ-009 SHALL have ports dma_req, dma_lock, dma_we  in  1 each, dma_addr  in  AW, dma_wdata  in  8: SPI DMA request; lock marks an active burst.
REQ-010 SHALL have ports dma_gnt, dma_rvalid  out  1 each: DMA grant and read-data-valid.
REQ-011 SHALL have ports cpu_req, cpu_we  in  1 each, cpu_addr  in  AW, cpu_wdata  in  8: 6502 request.
REQ-012 SHALL have ports cpu_gnt, cpu_rvalid, cpu_stall  out  1 each: CPU grant, read-data-valid, stall.
REQ-013 SHALL have ports mem_addr  out  AW, mem_we  out  1, mem_wdata  out  8: single-port buffer RAM drive.
REQ-014 SHALL have ports mem_rdata  in  8 and rdata  out  8: RAM read data, broadcast to requesters.
REQ-015 SHALL have port owner  out  2: 0 idle, 1 WD, 2 DMA, 3 CPU.

Function
REQ-016 SHALL at each ce edge pick at most one winner among eligible requests, register its addr/we/wdata onto mem_*, set owner, and assert that requester's gnt for exactly the following ce cycle.
REQ-017 SHALL treat a request as ineligible on any edge where that requester's gnt is currently 1 (masking prevents duplicate service); one requester therefore gets at most one access per 2 ce cycles.
REQ-018 SHALL use priority WD > DMA > CPU, except as in REQ-020.
REQ-019 SHALL, while dma_lock=1 and dma_req=1, keep DMA ahead of CPU; WD still preempts DMA at any access boundary.
REQ-020 SHALL keep a saturating counter cpu_wait: +1 on each ce edge where the CPU is eligible and loses; cleared on CPU grant or cpu_req=0; when cpu_wait = STARVE_MAX the CPU wins over DMA (locked or not) and over WD.
REQ-021 SHALL, with no eligible request, drive owner=0, mem_we=0, all gnt=0; mem_addr holds its last value.
REQ-022 SHALL assert x_rvalid for exactly the ce cycle after a read grant of x (we=0); rdata = mem_rdata combinationally; writes produce no rvalid.
REQ-023 SHALL drive mem_we=1 only during a write grant cycle.
REQ-024 SHALL drive cpu_stall = cpu_req & ~cpu_gnt combinationally.
REQ-025 SHALL, when ce=0, hold all registered outputs and counters unchanged.
REQ-026 SHALL allow a new grant to a different requester in the cycle an rvalid is asserted (back-to-back accesses).

Reset
REQ-027 SHALL on reset_n=0 immediately force owner=0, all gnt/rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_wait=0, regardless of ce.
REQ-028 SHALL discard an in-flight access on reset; no rvalid follows release of reset.

Verification
REQ-029 Simultaneous wd_req(rd,0x005), dma_req(wr,0x100,0xA5), cpu_req(rd,0x010), ce=1 -> grants WD, DMA, CPU on consecutive cycles; wd_rvalid one cycle after wd_gnt; mem_we=1 only on DMA cycle with mem_wdata=0xA5.
REQ-030 dma_req+dma_lock held continuously with new address each grant, cpu_req held -> CPU granted on the edge after its 8th loss; cpu_stall=1 until then.
REQ-031 ce toggling 1,0,0,1 during WD read -> gnt/rvalid widths stretch over ce=0 cycles; exactly one rvalid issued.
REQ-032 reset_n pulsed low while cpu_gnt=1 for a read -> outputs zero asynchronously; cpu_rvalid never asserted after release.
REQ-033 cpu_req held high alone for 6 ce cycles, same address -> cpu_gnt pattern 1,0,1,0,1,0; owner alternates 3,0.
REQ-034 Write 0x3C to 0x3FF via WD, then CPU read 0x3FF -> cpu_rvalid with rdata=0x3C; mem_addr=0x3FF (no wrap error).
